ex_mem_stage: RTL and testbench

- EX/MEM pipeline boundary directly downstream of the ALU, including the RED reduction unit.
- Latches the ALU result, store data and control bits for the memory stage.
- Owns the architectural flag register (Z, V, N) and applies the per-opcode flag-update rules.
- Provides a sticky halt indication and a retired-op counter for the bench.

---
 rtl/ex_mem_stage.sv | 110 +++++++++++
 tb/tb_ex_mem_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: latches ALU result, store data and controls, owns Z/V/N flags, sticky halt and retired count.
// One-cycle latency; stall holds every register, flush, idle and halted cycles insert a bubble.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_ovfl,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_halt,
  output logic              mem_valid,
  output logic [3:0]        mem_opcode,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_dst,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic commit;
  logic updZ;
  logic updVn;
  logic resZero;
  logic retiredMax;

  assign commit     = ex_valid & ~flush & ~stall & ~halted;
  assign resZero    = (ex_alu_result == '0);
  assign retiredMax = (retired == 16'hFFFF);

  // Arithmetic ops set all three flags; logic/shift ops only touch Z.
  always_comb begin
    updZ  = 1'b0;
    updVn = 1'b0;
    case (ex_opcode)
      OP_ADD, OP_SUB: begin
        updZ  = 1'b1;
        updVn = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: updZ = 1'b1;
      default: begin
        updZ  = 1'b0;
        updVn = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_dst        <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      flag_z         <= 1'b0;
      flag_v         <= 1'b0;
      flag_n         <= 1'b0;
      halted         <= 1'b0;
      retired        <= '0;
    end else if (flush || (!stall && !commit)) begin
      // Bubble: data fields keep stale values, only valid and controls drop.
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
    end else if (commit) begin
      mem_valid      <= 1'b1;
      mem_opcode     <= ex_opcode;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      mem_dst        <= ex_dst;
      mem_reg_write  <= ex_reg_write;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      if (updZ) flag_z <= resZero;
      if (updVn) begin
        flag_v <= ex_ovfl;
        flag_n <= ex_alu_result[DATA_W-1];
      end
      if (ex_halt) halted <= 1'b1;
      if (!retiredMax) retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_alu_result;
  logic        ex_ovfl;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_halt;
  logic        mem_valid;
  logic [3:0]  mem_opcode;
  logic [15:0] mem_alu_result, mem_store_data;
  logic [3:0]  mem_dst;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic        flag_z, flag_v, flag_n, halted;
  logic [15:0] retired;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result),
    .ex_ovfl(ex_ovfl), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_dst(mem_dst),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .halted(halted), .retired(retired)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic rw, input logic mr, input logic mw,
                         input logic hlt);
    ex_valid      = v;
    ex_opcode     = op;
    ex_alu_result = res;
    ex_ovfl       = ov;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_halt       = hlt;
  endtask

  task automatic checkFlags(input string tag, input logic z, input logic v, input logic n);
    checkVal({tag, ".z"}, {31'd0, flag_z}, {31'd0, z});
    checkVal({tag, ".v"}, {31'd0, flag_v}, {31'd0, v});
    checkVal({tag, ".n"}, {31'd0, flag_n}, {31'd0, n});
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".valid"}, {31'd0, mem_valid}, 32'd0);
    checkVal({tag, ".opcode"}, {28'd0, mem_opcode}, 32'd0);
    checkVal({tag, ".result"}, {16'd0, mem_alu_result}, 32'd0);
    checkVal({tag, ".store"}, {16'd0, mem_store_data}, 32'd0);
    checkVal({tag, ".dst"}, {28'd0, mem_dst}, 32'd0);
    checkVal({tag, ".ctl"}, {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
    checkFlags(tag, 1'b0, 1'b0, 1'b0);
    checkVal({tag, ".halted"}, {31'd0, halted}, 32'd0);
    checkVal({tag, ".retired"}, {16'd0, retired}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_store_data = 16'h0; ex_dst = 4'h0;
    present(1'b1, 4'b0000, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    checkAllZero("reset");

    // ADD, zero result with overflow
    rst = 1'b0;
    ex_store_data = 16'hAAAA; ex_dst = 4'd3;
    present(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkVal("add.valid", {31'd0, mem_valid}, 32'd1);
    checkVal("add.result", {16'd0, mem_alu_result}, 32'h0000);
    checkVal("add.store", {16'd0, mem_store_data}, 32'hAAAA);
    checkVal("add.dst", {28'd0, mem_dst}, 32'd3);
    checkVal("add.rw", {31'd0, mem_reg_write}, 32'd1);
    checkFlags("add", 1'b1, 1'b1, 1'b0);
    checkVal("add.retired", {16'd0, retired}, 32'd1);

    present(1'b1, 4'b0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkFlags("sub", 1'b0, 1'b0, 1'b1);
    checkVal("sub.retired", {16'd0, retired}, 32'd2);

    // XOR updates Z only; the ovfl=1 must not reach V
    present(1'b1, 4'b0010, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkFlags("xor", 1'b1, 1'b0, 1'b1);

    present(1'b1, 4'b0011, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkFlags("red", 1'b1, 1'b0, 1'b1);
    checkVal("red.opcode", {28'd0, mem_opcode}, 32'd3);

    present(1'b1, 4'b0111, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkFlags("paddsb", 1'b1, 1'b0, 1'b1);
    checkVal("paddsb.result", {16'd0, mem_alu_result}, 32'h1234);
    checkVal("paddsb.retired", {16'd0, retired}, 32'd5);

    present(1'b1, 4'b1000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkFlags("lw", 1'b1, 1'b0, 1'b1);
    checkVal("lw.mr", {31'd0, mem_mem_read}, 32'd1);

    present(1'b1, 4'b0100, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkFlags("sll", 1'b0, 1'b0, 1'b1);
    checkVal("sll.retired", {16'd0, retired}, 32'd7);

    // Stall: everything frozen while valid ADDs are offered
    stall = 1'b1;
    present(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("stall.valid", {31'd0, mem_valid}, 32'd1);
      checkVal("stall.result", {16'd0, mem_alu_result}, 32'h8001);
      checkVal("stall.opcode", {28'd0, mem_opcode}, 32'd4);
      checkVal("stall.mw", {31'd0, mem_mem_write}, 32'd0);
      checkFlags("stall", 1'b0, 1'b0, 1'b1);
      checkVal("stall.retired", {16'd0, retired}, 32'd7);
    end
    flush = 1'b1;
    tick();
    checkVal("stflush.valid", {31'd0, mem_valid}, 32'd0);
    checkVal("stflush.rw", {31'd0, mem_reg_write}, 32'd0);
    checkFlags("stflush", 1'b0, 1'b0, 1'b1);
    checkVal("stflush.retired", {16'd0, retired}, 32'd7);
    stall = 1'b0; flush = 1'b0;

    present(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkVal("idle.valid", {31'd0, mem_valid}, 32'd0);
    checkVal("idle.ctl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
    checkFlags("idle", 1'b0, 1'b0, 1'b1);

    // read and write together are latched unchecked
    present(1'b1, 4'b1001, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkVal("rdwr.ctl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd3);
    checkVal("rdwr.retired", {16'd0, retired}, 32'd8);

    present(1'b1, 4'b1111, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkVal("hlt.halted", {31'd0, halted}, 32'd1);
    checkVal("hlt.valid", {31'd0, mem_valid}, 32'd1);
    checkVal("hlt.retired", {16'd0, retired}, 32'd9);

    present(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkVal("posthlt.valid", {31'd0, mem_valid}, 32'd0);
    checkFlags("posthlt", 1'b0, 1'b0, 1'b1);
    checkVal("posthlt.retired", {16'd0, retired}, 32'd9);
    checkVal("posthlt.halted", {31'd0, halted}, 32'd1);

    rst = 1'b1;
    tick();
    checkVal("hltrst.halted", {31'd0, halted}, 32'd0);

    // Reset while a store sits in MEM
    rst = 1'b0;
    ex_store_data = 16'h5A5A; ex_dst = 4'd9;
    present(1'b1, 4'b1001, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkVal("sw.valid", {31'd0, mem_valid}, 32'd1);
    checkVal("sw.mw", {31'd0, mem_mem_write}, 32'd1);
    rst = 1'b1;
    present(1'b1, 4'b0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkAllZero("midrst");

    // Saturation
    rst = 1'b0; ex_store_data = 16'h0; ex_dst = 4'h0;
    present(1'b1, 4'b0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    checkVal("sat.fffe", {16'd0, retired}, 32'hFFFE);
    tick();
    checkVal("sat.ffff", {16'd0, retired}, 32'hFFFF);
    tick();
    checkVal("sat.hold", {16'd0, retired}, 32'hFFFF);
    checkVal("sat.valid", {31'd0, mem_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
